// File: rtl/scan_loader_if.sv
// Host-side configuration word bus: valid/ready handshake carrying 32-bit bitstream words.
// No logic inside; the loader is the slave and the bitstream source is the master.
// A word moves on any rising clk edge where cfg_valid && cfg_ready.
interface scan_loader_if;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [31:0] cfg_data;

  modport master (output cfg_valid, output cfg_data, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_data, output cfg_ready);
endinterface

// File: rtl/scan_loader.sv
// Serialises a 32-bit word stream into the CLB chain, then the connection chain, two clk cycles per bit.
// Latency: a word accepted in cycle N drives its bit 0 in N+1 (phase 0); scan_clk rises in N+2.
// Backpressure: cfg_ready only while loading with an empty buffer; optional readback (SCAN_LOADER_READBACK_EN) has none.
module scan_loader #(
  parameter int CLB_BITS  = 2048,
  parameter int CONN_BITS = 8192
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  scan_loader_if.slave cfg,
  output logic         scan_clk,
  output logic         clb_scan_in,
  output logic         clb_scan_en,
  output logic         conn_scan_in,
  output logic         conn_scan_en,
  output logic         busy,
  output logic         done
`ifdef SCAN_LOADER_READBACK_EN
  ,
  input  logic         clb_scan_out,
  input  logic         conn_scan_out,
  output logic         rb_valid,
  output logic [31:0]  rb_data
`endif
);

  localparam int MAX_BITS = (CLB_BITS > CONN_BITS) ? CLB_BITS : CONN_BITS;
  localparam int CNT_W    = $clog2(MAX_BITS + 1);

  typedef enum logic [1:0] {IDLE, LOAD_CLB, LOAD_CONN, DONE} state_e;

  state_e           state_q, state_d;
  logic             phase_q, phase_d;   // 0: set up scan_in, 1: scan_clk high
  logic [31:0]      word_q, word_d;     // current word, bit 0 is next out
  logic [5:0]       bits_q, bits_d;     // bits left in word_q (0 = empty)
  logic [CNT_W-1:0] cnt_q, cnt_d;       // bits left in the active chain

  logic in_load;
  logic shift_bit;
  logic last_bit;

  assign in_load   = (state_q == LOAD_CLB) || (state_q == LOAD_CONN);
  assign shift_bit = in_load && phase_q;
  assign last_bit  = shift_bit && (cnt_q == CNT_W'(1));

  assign cfg.cfg_ready = in_load && (bits_q == 6'd0);
  assign scan_clk      = phase_q;
  assign clb_scan_en   = (state_q == LOAD_CLB);
  assign conn_scan_en  = (state_q == LOAD_CONN);
  assign clb_scan_in   = clb_scan_en && word_q[0];
  assign conn_scan_in  = conn_scan_en && word_q[0];
  assign busy          = in_load;
  assign done          = (state_q == DONE);

  // State register and datapath flops, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= 1'b0;
      word_q  <= '0;
      bits_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      word_q  <= word_d;
      bits_q  <= bits_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: word intake, two-phase bit shifting, chain hand-over
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    word_d  = word_q;
    bits_d  = bits_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOAD_CLB, LOAD_CONN: begin
        if (cfg.cfg_ready && cfg.cfg_valid) begin
          word_d = cfg.cfg_data;
          bits_d = 6'd32;
        end else if (!phase_q) begin
          // an empty buffer stalls here with scan_clk low
          if (bits_q != 6'd0) phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          word_d  = word_q >> 1;
          bits_d  = bits_q - 6'd1;
          if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
          if (last_bit) begin
            // leftover bits of a word never spill into the next chain
            word_d = '0;
            bits_d = '0;
            if (state_q == LOAD_CLB) begin
              state_d = LOAD_CONN;
              cnt_d   = CNT_W'(CONN_BITS);
            end else begin
              state_d = DONE;
            end
          end
        end
      end
      default: begin
        if (start) begin
          state_d = LOAD_CLB;
          phase_d = 1'b0;
          word_d  = '0;
          bits_d  = '0;
          cnt_d   = CNT_W'(CLB_BITS);
        end
      end
    endcase
  end

`ifdef SCAN_LOADER_READBACK_EN
  logic [4:0]  rb_cnt_q, rb_cnt_d;
  logic [31:0] rb_sr_q, rb_sr_d;
  logic [31:0] rb_data_q, rb_data_d;
  logic        rb_valid_q, rb_valid_d;
  logic        rb_bit;
  logic [31:0] rb_word;

  assign rb_bit   = clb_scan_en ? clb_scan_out : conn_scan_out;
  assign rb_valid = rb_valid_q;
  assign rb_data  = rb_data_q;

  // Readback flops, synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      rb_cnt_q   <= '0;
      rb_sr_q    <= '0;
      rb_data_q  <= '0;
      rb_valid_q <= 1'b0;
    end else begin
      rb_cnt_q   <= rb_cnt_d;
      rb_sr_q    <= rb_sr_d;
      rb_data_q  <= rb_data_d;
      rb_valid_q <= rb_valid_d;
    end
  end

  // Collect scan_out bits by position; flush on full word or chain end (zero high bits)
  always_comb begin
    rb_cnt_d   = rb_cnt_q;
    rb_sr_d    = rb_sr_q;
    rb_data_d  = rb_data_q;
    rb_valid_d = 1'b0;
    rb_word    = rb_sr_q;
    rb_word[rb_cnt_q] = rb_bit;
    if (shift_bit) begin
      if (last_bit || (rb_cnt_q == 5'd31)) begin
        rb_valid_d = 1'b1;
        rb_data_d  = rb_word;
        rb_sr_d    = '0;
        rb_cnt_d   = '0;
      end else begin
        rb_sr_d  = rb_word;
        rb_cnt_d = rb_cnt_q + 5'd1;
      end
    end
  end
`endif

endmodule

// File: doc/scan_loader.md
SCAN_LOADER -- requirements
Module: scan_loader

Interface
REQ-001 Parameter CLB_BITS, default 2048: length of the CLB configuration scan chain, in bits.
REQ-002 Parameter CONN_BITS, default 8192: length of the connection configuration scan chain, in bits.
REQ-003 clk  input  1  system clock; the block has one clock, and all logic is registered on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  one-cycle request to begin a full configuration load.
REQ-006 cfg_valid  input  1  bitstream word valid (host side).
REQ-007 cfg_ready  output  1  block accepts a word when cfg_valid && cfg_ready.
REQ-008 cfg_data  input  32  bitstream word, shifted LSB first.
REQ-009 scan_clk  output  1  registered scan clock driven to the fabric.
REQ-010 clb_scan_in, clb_scan_en  output  1 each  CLB chain serial data and shift enable.
REQ-011 conn_scan_in, conn_scan_en  output  1 each  connection chain serial data and shift enable.
REQ-012 busy  output  1  high from the cycle after an accepted start until DONE is entered.
REQ-013 done  output  1  high in DONE, cleared by the next accepted start or by reset.

Function
REQ-014 FSM states and transitions:
- IDLE -> LOAD_CLB on start.
- LOAD_CLB -> LOAD_CONN after CLB_BITS bits have been shifted.
- LOAD_CONN -> DONE after CONN_BITS bits have been shifted.
- DONE -> LOAD_CLB on start.
REQ-015 start is ignored while in LOAD_CLB or LOAD_CONN.
REQ-016 Word buffer: one 32-bit shift register plus a 6-bit count of remaining bits.
- cfg_ready = 1 only in a LOAD state with the buffer empty.
- A word accepted in cycle N is available for shifting in cycle N+1.
REQ-017 Each bit takes two clk cycles:
- Phase 0: scan_clk=0 and the active chain's scan_in = buf[0].
- Phase 1: scan_clk=1 with scan_in held; the buffer shifts right and both counters decrement at the end of phase 1.
REQ-018 When the buffer is empty, scan_clk holds 0 and no bit is shifted (stall); stalls may be of any length.
REQ-019 Scan enables:
- clb_scan_en is high for the whole LOAD_CLB state, including stalls.
- conn_scan_en is high for the whole LOAD_CONN state, including stalls.
- At most one enable is high at a time.
REQ-020 The inactive chain's scan_in is 0.
REQ-021 The chain bit counter is ceil(log2(max(CLB_BITS,CONN_BITS)+1)) bits wide and counts down to 0 with no wrap-around.
REQ-022 Chain boundary: when a chain count reaches 0 mid-word, the remaining buffer bits are discarded and the buffer is marked empty.
- The CONN chain always starts on a fresh word.
REQ-023 The transition LOAD_CONN -> DONE occurs in the cycle after the last phase 1.
- scan_clk=0 and both enables are low in DONE.
REQ-024 A cfg_valid asserted in IDLE or DONE is not accepted (cfg_ready=0).

Reset
REQ-025 On reset:
- state=IDLE.
- scan_clk, clb_scan_in, clb_scan_en, conn_scan_in, conn_scan_en, cfg_ready, busy and done all = 0.
- The buffer is emptied and the counters are cleared.
REQ-026 Reset asserted mid-load aborts the load, with all outputs at reset values the next cycle; no partial-state resume.

Configuration
REQ-027 Macro SCAN_LOADER_READBACK_EN adds three readback ports:
- clb_scan_out and conn_scan_out: inputs, 1 bit each.
- rb_valid: output, 1 bit.
- rb_data: output, 32 bits.
REQ-028 With SCAN_LOADER_READBACK_EN defined, readback capture works as follows:
- In each phase 1, the active chain's scan_out is sampled into a 32-bit readback shift register, LSB-first order.
- rb_valid pulses for one cycle when 32 bits, or the final partial word of a chain, have been collected.
- A partial word is zero-padded in its high bits.
- There is no backpressure.
- rb_valid and rb_data reset to 0.
REQ-029 Without SCAN_LOADER_READBACK_EN, those ports and their logic are absent; all other behaviour is identical.

Verification (CLB_BITS=40, CONN_BITS=8)
REQ-030 Reset, then start; feed words 0xA5A5A5A5, 0x000000FF, 0x0000003C.
- CLB chain sees 40 bits: A5A5A5A5 LSB-first, then FF low byte.
- CONN chain sees 0x3C LSB-first.
- done=1.
- Total scan_clk rising edges = 48.
REQ-031 Hold cfg_valid=0 for 10 cycles mid-load -> scan_clk holds 0, clb_scan_en stays 1, no bits are lost, and the final chain contents are unchanged.
REQ-032 Assert start during LOAD_CLB -> no effect; busy stays 1 and the bit count is unaffected.
REQ-033 Assert reset after 20 CLB bits -> next cycle all outputs are 0 and state is IDLE; a following start reloads from bit 0.
REQ-034 With SCAN_LOADER_READBACK_EN, loop back clb_scan_out=clb_scan_in and conn_scan_out=conn_scan_in, then run the REQ-030 sequence. Required rb_valid pulses, in order:
- rb_data=0xA5A5A5A5
- rb_data=0x000000FF
- rb_data=0x0000003C
